// File: rtl/memory_arb_pkg.sv
// rtl/memory_arb_pkg.sv - shared encodings for the two-port memory arbiter
//
// Purpose: state encoding and port index constants used by memory_arbiter_2
//          and mem_arb_pick.
// Ports:   none (package).
package memory_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_A = 2'd1;
  localparam logic [1:0] ST_GNT_B = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GNT_A = ST_GNT_A,
    GNT_B = ST_GNT_B
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection for the memory arbiter
//
// Purpose: picks which pending port gets the next grant. Default build is
//          round-robin (a tie goes to the port that was not served last).
//          Build macro MEM_ARB_FIXED_PRIO_EN: a tie always goes to port A and
//          last is ignored.
// Ports:
//   pend_a  in   port A has a read or write pending
//   pend_b  in   port B has a read or write pending
//   last    in   port served by the most recent completion
//   win     out  winning port (PORT_A / PORT_B), meaningful when valid=1
//   valid   out  at least one port is pending
module mem_arb_pick
  import memory_arb_pkg::*;
(
  input  logic pend_a,
  input  logic pend_b,
  input  logic last,
  output logic win,
  output logic valid
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    valid = pend_a | pend_b;
    win   = PORT_A;
    if (pend_a && pend_b) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win = PORT_A;
`else
      win = (last == PORT_A) ? PORT_B : PORT_A;
`endif
    end else if (pend_b) begin
      win = PORT_B;
    end
  end

endmodule

// File: rtl/memory_arbiter_2.sv
// rtl/memory_arbiter_2.sv - two-master arbiter sharing one read/write/waitrequest memory
//
// Purpose: grants ports A and B access to one memory, holding each grant until
//          the memory completes the transfer or the master withdraws. One IDLE
//          cycle always separates grants. Arbitration policy lives in
//          mem_arb_pick (build macro MEM_ARB_FIXED_PRIO_EN selects fixed A priority).
// Ports:
//   i_clk, i_reset_n                        clock, synchronous active-low reset
//   i_a_* / o_a_*                           master port A (address, read, write,
//                                           writedata, readdata, waitrequest)
//   i_b_* / o_b_*                           master port B, same set
//   o_m_address/read/write/writedata        request towards the memory
//   i_m_readdata, i_m_waitrequest           response from the memory
module memory_arbiter_2
  import memory_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 36
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,

  input  logic [ADDR_WIDTH-1:0] i_a_address,
  input  logic                  i_a_read,
  input  logic                  i_a_write,
  input  logic [DATA_WIDTH-1:0] i_a_writedata,
  output logic [DATA_WIDTH-1:0] o_a_readdata,
  output logic                  o_a_waitrequest,

  input  logic [ADDR_WIDTH-1:0] i_b_address,
  input  logic                  i_b_read,
  input  logic                  i_b_write,
  input  logic [DATA_WIDTH-1:0] i_b_writedata,
  output logic [DATA_WIDTH-1:0] o_b_readdata,
  output logic                  o_b_waitrequest,

  output logic [ADDR_WIDTH-1:0] o_m_address,
  output logic                  o_m_read,
  output logic                  o_m_write,
  output logic [DATA_WIDTH-1:0] o_m_writedata,
  input  logic [DATA_WIDTH-1:0] i_m_readdata,
  input  logic                  i_m_waitrequest
);

  arb_state_e state;
  logic       last;

  logic pend_a;
  logic pend_b;
  logic pick_win;
  logic pick_valid;

  assign pend_a = i_a_read | i_a_write;
  assign pend_b = i_b_read | i_b_write;

  mem_arb_pick u_pick (
    .pend_a (pend_a),
    .pend_b (pend_b),
    .last   (last),
    .win    (pick_win),
    .valid  (pick_valid)
  );

  // Every grant returns to IDLE, whether it completed or was withdrawn, so
  // grants are never chained. Only a completion moves last.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      last  <= PORT_B;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= (pick_win == PORT_A) ? GNT_A : GNT_B;
          end
        end
        GNT_A: begin
          if (pend_a && !i_m_waitrequest) begin
            state <= IDLE;
            last  <= PORT_A;
          end else if (!pend_a) begin
            state <= IDLE;
          end
        end
        GNT_B: begin
          if (pend_b && !i_m_waitrequest) begin
            state <= IDLE;
            last  <= PORT_B;
          end else if (!pend_b) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side mux. Gated by i_reset_n so a reset during a grant removes the
  // request from the memory immediately, not one edge later. Read+write
  // together is presented as a write.
  always_comb begin
    o_m_address     = '0;
    o_m_read        = 1'b0;
    o_m_write       = 1'b0;
    o_m_writedata   = '0;
    o_a_waitrequest = 1'b1;
    o_b_waitrequest = 1'b1;
    if (i_reset_n) begin
      case (state)
        GNT_A: begin
          o_m_address     = i_a_address;
          o_m_read        = i_a_read & ~i_a_write;
          o_m_write       = i_a_write;
          o_m_writedata   = i_a_writedata;
          o_a_waitrequest = i_m_waitrequest;
        end
        GNT_B: begin
          o_m_address     = i_b_address;
          o_m_read        = i_b_read & ~i_b_write;
          o_m_write       = i_b_write;
          o_m_writedata   = i_b_writedata;
          o_b_waitrequest = i_m_waitrequest;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_a_readdata = i_m_readdata;
  assign o_b_readdata = i_m_readdata;

endmodule
